// File: rtl/mul_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg (package)
// Description : Shared types and helpers for the mul_chain sequential
//               selectable-product unit.
//               - mul_state_t : controller state encoding
//               - fits_signed : checks that a signed product (held sign-extended
//                               in 64 bits) is representable in 'width' signed
//                               bits
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Widest full product the helper can check (2*WIDTH must not exceed this).
    localparam int c_FIT_MAX_W = 64;

    // A value fits in 'width' signed bits when every bit from the target sign
    // bit upward is a copy of that sign bit, i.e. the arithmetic shift leaves
    // all zeros or all ones.
    function automatic logic fits_signed(input logic signed [c_FIT_MAX_W-1:0] full,
                                         input int                            width);
        logic signed [c_FIT_MAX_W-1:0] hi;
        hi = full >>> (width - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_chain_mult.sv
`default_nettype none
// ============================================================================
// Module      : mult_w
// Description : Signed combinational WIDTH x WIDTH multiplier shared by all
//               steps of mul_chain.
// Ports       : i_a, i_b   - signed operands (WIDTH)
//               prod_lo    - low WIDTH bits of the product (wrap-around)
//               prod_full  - full 2*WIDTH signed product
// Config      : SYNTHESIS selects the dedicated-multiplier (DSP) mapping;
//               otherwise a plain behavioural multiply is used.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [WIDTH-1:0]   prod_lo,
    output logic [2*WIDTH-1:0] prod_full
);

`ifdef SYNTHESIS
    // Steer the multiply onto the vendor's hard multiplier block.
    (* use_dsp = "yes" *) logic signed [2*WIDTH-1:0] w_full;
`else
    logic signed [2*WIDTH-1:0] w_full;
`endif

    // Operands are sign-extended to the 2*WIDTH context before multiplying.
    assign w_full    = $signed(i_a) * $signed(i_b);
    assign prod_full = w_full;
    assign prod_lo   = w_full[WIDTH-1:0];

endmodule : mult_w
`default_nettype wire

// File: rtl/mul_chain.sv
`default_nettype none
// ============================================================================
// Module      : mul_chain
// Description : Signed product of any subset of NUM_OPS operands selected by a
//               mask, computed iteratively on one shared multiplier (one
//               operand per cycle) behind valid/ready handshakes. Latency is
//               fixed at NUM_OPS cycles from accept to out_valid.
// Ports       : clk, n_reset (async, active-low)
//               in_valid / in_ready   - request handshake
//               ops [NUM_OPS*WIDTH]   - packed operands, op[i] at i*WIDTH
//               sel [NUM_OPS]         - operand select mask
//               out_valid / out_ready - result handshake
//               result [WIDTH]        - truncated signed product
//               ovf                   - sticky overflow (MUL_CHAIN_OVF_EN only)
// Config      : MUL_CHAIN_OVF_EN adds the ovf port and its detection logic.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_chain
    import mul_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_OPS = 3,
    localparam int IDX_W   = $clog2(NUM_OPS + 1)
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] ops,
    input  logic [NUM_OPS-1:0]       sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result
`ifdef MUL_CHAIN_OVF_EN
    ,
    output logic                     ovf
`endif
);

    mul_state_t               r_state;
    mul_state_t               w_state_nxt;

    logic [NUM_OPS*WIDTH-1:0] r_ops;
    logic [NUM_OPS-1:0]       r_sel;
    logic [WIDTH-1:0]         r_acc;
    logic [IDX_W-1:0]         r_idx;

    logic                     w_accept;
    logic                     w_step;
    logic                     w_last;
    logic [WIDTH-1:0]         w_op;
    logic                     w_sel_bit;
    logic [WIDTH-1:0]         w_prod_lo;
    logic [2*WIDTH-1:0]       w_prod_full;

    // ------------------------------------------------------------------
    // Current-step operand / select bit. Compare-and-pick keeps indexing
    // clean for any NUM_OPS, independent of the counter width.
    // ------------------------------------------------------------------
    always_comb begin
        w_op      = '0;
        w_sel_bit = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_op      = r_ops[i*WIDTH +: WIDTH];
                w_sel_bit = r_sel[i];
            end
        end
    end

    assign w_last = (r_idx == IDX_W'(NUM_OPS - 1));

    mult_w #(
        .WIDTH     (WIDTH)
    ) u_mult (
        .i_a       (r_acc),
        .i_b       (w_op),
        .prod_lo   (w_prod_lo),
        .prod_full (w_prod_full)
    );

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. acc starts at 1 (multiplicative identity) when anything is
    // selected, else 0 so an empty mask yields 0. Every RUN cycle advances
    // idx whether or not the operand is selected, giving fixed latency.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_ops <= '0;
            r_sel <= '0;
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_ops <= ops;
            r_sel <= sel;
            r_acc <= (sel != '0) ? WIDTH'(1) : '0;
            r_idx <= '0;
        end else if (w_step) begin
            if (w_sel_bit) begin
                r_acc <= w_prod_lo;
            end
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // acc only changes in RUN, so it is stable throughout DONE.
    assign result = r_acc;

`ifdef MUL_CHAIN_OVF_EN
    logic                         r_ovf;
    logic signed [c_FIT_MAX_W-1:0] w_full_ext;

    assign w_full_ext = c_FIT_MAX_W'($signed(w_prod_full));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_step && w_sel_bit && !fits_signed(w_full_ext, WIDTH)) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    // Full product only feeds overflow detection.
    logic [2*WIDTH-1:0] w_unused_full;
    assign w_unused_full = w_prod_full;
`endif

endmodule : mul_chain
`default_nettype wire

// File: tb/tb_mul_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_chain
// Description : Directed self-checking bench for mul_chain. Instance u_dut3
//               uses WIDTH=8/NUM_OPS=3, instance u_dut5 uses WIDTH=16/
//               NUM_OPS=5. Inputs change on the falling edge; outputs are
//               sampled #1 after the rising edge or on the falling edge.
// Config      : MUL_CHAIN_OVF_EN also checks the ovf flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_reset;

    // 8-bit, 3-operand instance
    logic        in_valid3, in_ready3, out_valid3, out_ready3;
    logic [23:0] ops3;
    logic [2:0]  sel3;
    logic [7:0]  result3;
`ifdef MUL_CHAIN_OVF_EN
    logic        ovf3;
`endif

    // 16-bit, 5-operand instance
    logic        in_valid5, in_ready5, out_valid5, out_ready5;
    logic [79:0] ops5;
    logic [4:0]  sel5;
    logic [15:0] result5;
`ifdef MUL_CHAIN_OVF_EN
    logic        ovf5;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mul_chain #(.WIDTH(8), .NUM_OPS(3)) u_dut3 (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .ops       (ops3),
        .sel       (sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .result    (result3)
`ifdef MUL_CHAIN_OVF_EN
        ,
        .ovf       (ovf3)
`endif
    );

    mul_chain #(.WIDTH(16), .NUM_OPS(5)) u_dut5 (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .ops       (ops5),
        .sel       (sel5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .result    (result5)
`ifdef MUL_CHAIN_OVF_EN
        ,
        .ovf       (ovf5)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request on the 3-op unit and hold in_valid for one edge.
    task automatic req3(input logic [23:0] o, input logic [2:0] s);
        @(negedge clk);
        ops3      = o;
        sel3      = s;
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        ops3      = 24'hA5A5A5;   // must be ignored from here on
        sel3      = 3'b101;
    endtask

    // Count rising edges after accept until out_valid (bounded).
    task automatic wait_done3(output int edges);
        edges = 0;
        while (out_valid3 !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Complete the result handshake and check the unit returns to IDLE.
    task automatic drain3(input string tag);
        @(negedge clk);
        out_ready3 = 1'b1;
        @(posedge clk);
        #1;
        out_ready3 = 1'b0;
        chk({tag, "_ov_low"}, 32'(out_valid3), 32'd0);
        chk({tag, "_ir_high"}, 32'(in_ready3), 32'd1);
    endtask

    task automatic run3(input string tag, input logic [23:0] o, input logic [2:0] s,
                        input logic [7:0] exp, input logic exp_ovf);
        int e;
        req3(o, s);
        chk({tag, "_ir_low"}, 32'(in_ready3), 32'd0);
        wait_done3(e);
        chk({tag, "_lat"}, 32'(e), 32'd3);
        chk({tag, "_res"}, 32'(result3), 32'(exp));
`ifdef MUL_CHAIN_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf3), 32'(exp_ovf));
`else
        if (exp_ovf) begin end
`endif
        drain3(tag);
    endtask

    initial begin
        int e;
        n_reset    = 1'b0;
        in_valid3  = 1'b0; out_ready3 = 1'b0; ops3 = '0; sel3 = '0;
        in_valid5  = 1'b0; out_ready5 = 1'b0; ops5 = '0; sel5 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready3), 32'd1);
        chk("rst_out_valid", 32'(out_valid3), 32'd0);
        chk("rst_result", 32'(result3), 32'd0);
`ifdef MUL_CHAIN_OVF_EN
        chk("rst_ovf", 32'(ovf3), 32'd0);
`endif
        @(negedge clk);
        n_reset = 1'b1;

        // ops packed {op2, op1, op0} = {5, -4, 3}: 3 * -4 * 5 = -60
        run3("all3", {8'sd5, -8'sd4, 8'sd3}, 3'b111, 8'hC4, 1'b0);
        // empty mask -> 0
        run3("empty", {8'sd9, 8'sd7, 8'sd5}, 3'b000, 8'h00, 1'b0);
        // single selected operand passes through unchanged
        run3("single", {8'sd9, -8'sd7, 8'sd5}, 3'b010, 8'hF9, 1'b0);
        // 100*100 = 10000 = 0x2710 -> wraps to 0x10, overflow
        run3("wrap", {8'sd0, 8'sd100, 8'sd100}, 3'b011, 8'h10, 1'b1);
        // next request clears ovf
        run3("clear", {8'sd0, 8'sd3, 8'sd2}, 3'b011, 8'h06, 1'b0);
        // zero operand kills the product, latency unchanged
        run3("zero", {8'sd7, 8'sd0, 8'sd6}, 3'b111, 8'h00, 1'b0);

        // Back-pressure: 2 * 3 * -1 = -6 held in DONE for 5 cycles while a
        // new request (4 * 5 = 20) waits on in_valid.
        req3({-8'sd1, 8'sd3, 8'sd2}, 3'b111);
        wait_done3(e);
        chk("bp_lat", 32'(e), 32'd3);
        @(negedge clk);
        ops3 = {8'sd0, 8'sd5, 8'sd4};
        sel3 = 3'b011;
        in_valid3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_res", 32'(result3), 32'hFA);
            chk("bp_ov", 32'(out_valid3), 32'd1);
            chk("bp_ir", 32'(in_ready3), 32'd0);
        end
        @(negedge clk);
        out_ready3 = 1'b1;
        @(posedge clk);
        #1;
        out_ready3 = 1'b0;
        chk("bp_idle_ir", 32'(in_ready3), 32'd1);
        chk("bp_idle_ov", 32'(out_valid3), 32'd0);
        @(posedge clk);      // pending request is accepted here
        #1;
        in_valid3 = 1'b0;
        chk("bp_acc_ir", 32'(in_ready3), 32'd0);
        wait_done3(e);
        chk("bp2_lat", 32'(e), 32'd3);
        chk("bp2_res", 32'(result3), 32'd20);
        drain3("bp2");

        // Reset in the middle of RUN (idx=1)
        req3({8'sd3, 8'sd3, 8'sd3}, 3'b111);
        @(posedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        chk("mrst_ir", 32'(in_ready3), 32'd1);
        chk("mrst_ov", 32'(out_valid3), 32'd0);
        chk("mrst_res", 32'(result3), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        // No stale product may survive: only op0 = 9 selected.
        run3("post_rst", {8'sd2, 8'sd2, 8'sd9}, 3'b001, 8'h09, 1'b0);

        // 16-bit, 5 operands: op0..op4 = 2, -3, 4, -5, 6; sel 10110 picks
        // op1, op2, op4 -> -3 * 4 * 6 = -72 = 16'hFFB8.
        @(negedge clk);
        ops5 = {16'sd6, -16'sd5, 16'sd4, -16'sd3, 16'sd2};
        sel5 = 5'b10110;
        in_valid5 = 1'b1;
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
        e = 0;
        while (out_valid5 !== 1'b1 && e < 20) begin
            @(negedge clk);
            ops5 = {16'sd100, 16'sd100, 16'sd100, 16'sd100, 16'sd100};
            sel5 = 5'b11111;
            @(posedge clk);
            #1;
            e++;
        end
        chk("w16_lat", 32'(e), 32'd5);
        chk("w16_res", 32'(result5), 32'hFFB8);
`ifdef MUL_CHAIN_OVF_EN
        chk("w16_ovf", 32'(ovf5), 32'd0);
`endif
        @(negedge clk);
        out_ready5 = 1'b1;
        @(posedge clk);
        #1;
        out_ready5 = 1'b0;
        chk("w16_idle", 32'(in_ready5), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mul_chain
`default_nettype wire
